huffman_code_table: RTL and testbench

Registered lookup table that maps a 7-bit ASCII character to a fixed canonical Huffman codeword and its length. It sits inside the Huffman coder, which presents a character on `ascii`. One clock later the coder samples `huffman_code` and `bit_length` in its ENCODE state and latches them for output. The code book is fixed at design time; there is no programmability.

---
 rtl/huffman_code_table.sv | 116 +++++++++++
 tb/tb_huffman_code_table.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_code_table.sv
// Fixed canonical Huffman code book for 7-bit ASCII.
// One registered stage: code and length load together every clock.
module huffman_code_table (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] ascii,
  output logic [9:0] huffman_code,
  output logic [3:0] bit_length
);

  logic [9:0] a10;
  logic [9:0] code_d;
  logic [3:0] len_d;

  assign a10 = {3'd0, ascii};

  // Lowercase letters carry the short codes; every other class is a
  // contiguous ASCII run, so its code is a base plus the run offset.
  always_comb begin
    code_d = '0;
    len_d  = '0;
    unique case (1'b1)
      (ascii < 7'h20): begin
        code_d = 10'd716 + a10;
        len_d  = 4'd10;
      end
      (ascii == 7'h20): begin
        code_d = 10'd0;
        len_d  = 4'd3;
      end
      (ascii >= 7'h21 && ascii <= 7'h2b): begin
        code_d = 10'd748 + (a10 - 10'h021);
        len_d  = 4'd10;
      end
      (ascii == 7'h2c): begin
        code_d = 10'd320;
        len_d  = 4'd9;
      end
      (ascii == 7'h2d): begin
        code_d = 10'd759;
        len_d  = 4'd10;
      end
      (ascii == 7'h2e): begin
        code_d = 10'd321;
        len_d  = 4'd9;
      end
      (ascii == 7'h2f): begin
        code_d = 10'd760;
        len_d  = 4'd10;
      end
      (ascii >= 7'h30 && ascii <= 7'h39): begin
        code_d = 10'd322 + (a10 - 10'h030);
        len_d  = 4'd9;
      end
      (ascii >= 7'h3a && ascii <= 7'h40): begin
        code_d = 10'd761 + (a10 - 10'h03a);
        len_d  = 4'd10;
      end
      (ascii >= 7'h41 && ascii <= 7'h5a): begin
        code_d = 10'd332 + (a10 - 10'h041);
        len_d  = 4'd9;
      end
      (ascii >= 7'h5b && ascii <= 7'h60): begin
        code_d = 10'd768 + (a10 - 10'h05b);
        len_d  = 4'd10;
      end
      (ascii >= 7'h61 && ascii <= 7'h7a): begin
        unique case (ascii)
          7'h61: {len_d, code_d} = {4'd5, 10'd8};
          7'h62: {len_d, code_d} = {4'd7, 10'd70};
          7'h63: {len_d, code_d} = {4'd6, 10'd30};
          7'h64: {len_d, code_d} = {4'd6, 10'd31};
          7'h65: {len_d, code_d} = {4'd4, 10'd2};
          7'h66: {len_d, code_d} = {4'd7, 10'd71};
          7'h67: {len_d, code_d} = {4'd7, 10'd72};
          7'h68: {len_d, code_d} = {4'd5, 10'd9};
          7'h69: {len_d, code_d} = {4'd5, 10'd10};
          7'h6a: {len_d, code_d} = {4'd8, 10'd156};
          7'h6b: {len_d, code_d} = {4'd7, 10'd73};
          7'h6c: {len_d, code_d} = {4'd6, 10'd32};
          7'h6d: {len_d, code_d} = {4'd6, 10'd33};
          7'h6e: {len_d, code_d} = {4'd5, 10'd11};
          7'h6f: {len_d, code_d} = {4'd5, 10'd12};
          7'h70: {len_d, code_d} = {4'd7, 10'd74};
          7'h71: {len_d, code_d} = {4'd8, 10'd157};
          7'h72: {len_d, code_d} = {4'd5, 10'd13};
          7'h73: {len_d, code_d} = {4'd5, 10'd14};
          7'h74: {len_d, code_d} = {4'd4, 10'd3};
          7'h75: {len_d, code_d} = {4'd6, 10'd34};
          7'h76: {len_d, code_d} = {4'd7, 10'd75};
          7'h77: {len_d, code_d} = {4'd7, 10'd76};
          7'h78: {len_d, code_d} = {4'd8, 10'd158};
          7'h79: {len_d, code_d} = {4'd7, 10'd77};
          7'h7a: {len_d, code_d} = {4'd8, 10'd159};
          default: {len_d, code_d} = '0;
        endcase
      end
      default: begin
        code_d = 10'd774 + (a10 - 10'h07b);
        len_d  = 4'd10;
      end
    endcase
  end

  // Output register; reset clears both fields without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      huffman_code <= '0;
      bit_length   <= '0;
    end else begin
      huffman_code <= code_d;
      bit_length   <= len_d;
    end
  end

endmodule

// File: tb/tb_huffman_code_table.sv
// Directed bench for huffman_code_table.
// Includes a canonical-assignment reference and a tiny coder stage.
module tb_huffman_code_table;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] ascii = '0;
  logic [9:0] huffman_code;
  logic [3:0] bit_length;

  int vectors = 0;
  int miscompares = 0;

  int         ref_len  [128];
  logic [9:0] ref_code [128];
  logic [9:0] got_code [128];
  logic [3:0] got_len  [128];

  logic       valid = 1'b0;
  logic       valid_d = 1'b0;
  logic       valid_out = 1'b0;
  logic [9:0] huffman_out = '0;
  logic [3:0] out_len = '0;

  huffman_code_table dut (
    .clk(clk),
    .reset(reset),
    .ascii(ascii),
    .huffman_code(huffman_code),
    .bit_length(bit_length)
  );

  always #5 clk = ~clk;

  // Consumer: enters ENCODE one edge after valid and latches the table.
  always @(posedge clk) begin
    valid_d   <= valid;
    valid_out <= valid_d;
    if (valid_d) begin
      huffman_out <= huffman_code;
      out_len     <= bit_length;
    end
  end

  function automatic int class_len(int c);
    if (c == 32) return 3;
    if (c == "e" || c == "t") return 4;
    if (c == "a" || c == "h" || c == "i" || c == "n" ||
        c == "o" || c == "r" || c == "s") return 5;
    if (c == "c" || c == "d" || c == "l" || c == "m" ||
        c == "u") return 6;
    if (c == "b" || c == "f" || c == "g" || c == "k" ||
        c == "p" || c == "v" || c == "w" || c == "y") return 7;
    if (c == "j" || c == "q" || c == "x" || c == "z") return 8;
    if (c == "," || c == "." || (c >= "0" && c <= "9") ||
        (c >= "A" && c <= "Z")) return 9;
    return 10;
  endfunction

  task automatic build_ref();
    int code = 0;
    int prev = 0;
    bit first = 1'b1;
    for (int c = 0; c < 128; c++) ref_len[c] = class_len(c);
    for (int l = 3; l <= 10; l++) begin
      for (int c = 0; c < 128; c++) begin
        if (ref_len[c] == l) begin
          if (first) code = 0;
          else code = (code + 1) << (l - prev);
          first = 1'b0;
          prev = l;
          ref_code[c] = code[9:0];
        end
      end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    ascii = 7'h65;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (huffman_code !== 10'd0 || bit_length !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h/%0d want 000/0",
               huffman_code, bit_length);
    end
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (huffman_code !== 10'h002 || bit_length !== 4'd4) begin
      miscompares++;
      $display("FAIL reset_release: got %h/%0d want 002/4",
               huffman_code, bit_length);
    end
  endtask

  task automatic test_short_codes();
    logic [6:0] ch [4] = '{7'h20, 7'h74, 7'h61, 7'h73};
    logic [9:0] cd [4] = '{10'h000, 10'h003, 10'h008, 10'h00e};
    logic [3:0] ln [4] = '{4'd3, 4'd4, 4'd5, 4'd5};
    logic [9:0] pc = 10'h002;
    logic [3:0] pl = 4'd4;
    ascii = 7'h65;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      ascii = ch[i];
      #1;
      vectors++;
      if (huffman_code !== pc || bit_length !== pl) begin
        miscompares++;
        $display("FAIL short_latency[%0d]: got %h/%0d want %h/%0d",
                 i, huffman_code, bit_length, pc, pl);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (huffman_code !== cd[i] || bit_length !== ln[i]) begin
        miscompares++;
        $display("FAIL short_code[%0d]: got %h/%0d want %h/%0d",
                 i, huffman_code, bit_length, cd[i], ln[i]);
      end
      pc = cd[i];
      pl = ln[i];
    end
  endtask

  task automatic test_class_boundaries();
    logic [6:0] ch [10] = '{7'h63, 7'h75, 7'h62, 7'h79, 7'h6a,
                           7'h7a, 7'h2c, 7'h5a, 7'h00, 7'h7f};
    int cd [10] = '{30, 34, 70, 77, 156, 159, 320, 357, 716, 778};
    int ln [10] = '{6, 6, 7, 7, 8, 8, 9, 9, 10, 10};
    for (int i = 0; i < 10; i++) begin
      ascii = ch[i];
      @(posedge clk);
      #1;
      vectors++;
      if (huffman_code !== cd[i][9:0] || bit_length !== ln[i][3:0]) begin
        miscompares++;
        $display("FAIL boundary[%h]: got %0d/%0d want %0d/%0d",
                 ch[i], huffman_code, bit_length, cd[i], ln[i]);
      end
    end
  endtask

  task automatic test_sweep();
    int kraft = 0;
    int clash = 0;
    build_ref();
    for (int c = 0; c < 128; c++) begin
      ascii = c[6:0];
      @(posedge clk);
      #1;
      got_code[c] = huffman_code;
      got_len[c]  = bit_length;
      vectors++;
      if (huffman_code !== ref_code[c] ||
          bit_length !== ref_len[c][3:0]) begin
        miscompares++;
        $display("FAIL sweep[%h]: got %0d/%0d want %0d/%0d",
                 c, huffman_code, bit_length, ref_code[c], ref_len[c]);
      end
      vectors++;
      if ((int'(huffman_code) >> bit_length) != 0) begin
        miscompares++;
        $display("FAIL width[%h]: got %0d/%0d want code < 2^len",
                 c, huffman_code, bit_length);
      end
      kraft += 1 << (10 - int'(bit_length));
    end
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < 128; j++)
        if (i != j && got_len[i] <= got_len[j] &&
            (got_code[j] >> (got_len[j] - got_len[i])) == got_code[i])
          clash++;
    vectors++;
    if (clash != 0) begin
      miscompares++;
      $display("FAIL prefix_free: got %0d clashes want 0", clash);
    end
    vectors++;
    if (kraft != 779) begin
      miscompares++;
      $display("FAIL kraft: got %0d/1024 want 779/1024", kraft);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) begin
      ascii = (i % 2 == 0) ? 7'h65 : 7'h5a;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (huffman_code !== 10'd357 || bit_length !== 4'd9) begin
      miscompares++;
      $display("FAIL alt_stream: got %0d/%0d want 357/9",
               huffman_code, bit_length);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (huffman_code !== 10'd0 || bit_length !== 4'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got %0d/%0d want 0/0",
               huffman_code, bit_length);
    end
    ascii = 7'h65;
    @(posedge clk);
    #1;
    vectors++;
    if (huffman_code !== 10'd0 || bit_length !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_edge: got %0d/%0d want 0/0",
               huffman_code, bit_length);
    end
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (huffman_code !== 10'd2 || bit_length !== 4'd4) begin
      miscompares++;
      $display("FAIL post_reset: got %0d/%0d want 2/4",
               huffman_code, bit_length);
    end
  endtask

  task automatic test_coder_integration();
    int n = 0;
    ascii = 7'h6e;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    while (!valid_out && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL coder_valid: got %b want 1 within 10 cycles",
               valid_out);
    end else begin
      vectors++;
      if (huffman_out !== 10'h00b || out_len !== 4'd5) begin
        miscompares++;
        $display("FAIL coder_out: got %h/%0d want 00b/5",
                 huffman_out, out_len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_codes();
    test_class_boundaries();
    test_sweep();
    test_mid_reset();
    test_coder_integration();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
